// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
//   Memory-mapped glue between a core's store/load strobes and an external
//   UART serializer/deserializer.
//
//   TX side: a byte register (tx_byte) loaded by stores to TX_DATA_ADDR, and
//   a four-state FSM that turns a start store into a single-cycle
//   uart_tx_start pulse. It then waits for the serializer to raise busy and
//   drop it again before it accepts another start.
//   RX side: rx_byte/rx_ready capture each uart_rx_done pulse. A store to
//   CLEAN_RX_ADDR clears rx_ready.
//
//   Handshake semantics: the core strobes (Tx_MemWrite, Tx_data_Memwrite,
//   Clean_rx_Memwrite) and uart_rx_done are single-cycle qualifiers sampled
//   on the rising edge, with no back-pressure. uart_tx_start is a one-cycle
//   request. The serializer acknowledges it by raising uart_tx_busy and
//   completes it by lowering uart_tx_busy.
//
//   Optional feature: define UART_RX_OVERRUN_EN to add a sticky overrun flag
//   (status bit 1). When the macro is undefined, the flag reads 0 and no
//   register is built for it.
//
// Ports
//   clk                 clock; all state updates happen on the rising edge
//   reset               asynchronous, active-low reset
//   WriteData           core store data
//   Tx_MemWrite         start command store (WriteData[0]=1 starts)
//   Tx_data_Memwrite    TX byte store (WriteData[7:0])
//   Clean_rx_Memwrite   clear rx_ready (and overrun)
//   Rx_ReadData         {zeros, rx_byte}
//   Rx_ready_ReadData   {zeros, tx_busy_flag, overrun, rx_ready}
//   uart_tx_start       one-cycle start pulse to the serializer
//   uart_tx_data        byte presented to the serializer
//   uart_tx_busy        serializer busy
//   uart_rx_done        received byte valid pulse
//   uart_rx_data        received byte
//   dbg_tx_state        current TX FSM state, for observation only
// ---------------------------------------------------------------------------
module uart_mmio_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Tx_MemWrite,
  input  logic                  Tx_data_Memwrite,
  input  logic                  Clean_rx_Memwrite,
  output logic [DATA_WIDTH-1:0] Rx_ReadData,
  output logic [DATA_WIDTH-1:0] Rx_ready_ReadData,
  output logic                  uart_tx_start,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_busy,
  input  logic                  uart_rx_done,
  input  logic [7:0]            uart_rx_data,
  output logic [1:0]            dbg_tx_state
);

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  tx_state_t  state, state_nxt;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       overrun_bit;

  // Only the low byte of store data is meaningful here.
  logic unused_wdata;
  assign unused_wdata = ^WriteData[DATA_WIDTH-1:8];

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    uart_tx_start = 1'b0;
    case (state)
      TX_IDLE: begin
        if (Tx_MemWrite && WriteData[0]) state_nxt = TX_START;
      end
      TX_START: begin
        uart_tx_start = 1'b1;
        state_nxt     = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (uart_tx_busy) state_nxt = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!uart_tx_busy) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // The byte may only change while idle. A data store together with a start
  // store in the same idle cycle therefore loads the byte before TX_START
  // presents it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    tx_byte <= 8'h00;
    else if (Tx_data_Memwrite && state == TX_IDLE) tx_byte <= WriteData[7:0];
  end

  assign uart_tx_data = tx_byte;
  assign dbg_tx_state = state;

  // ---------------- RX capture ----------------
  // rx_done takes priority over a simultaneous clean, so a byte that arrives
  // in the same cycle as the clear is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte  <= 8'h00;
      rx_ready <= 1'b0;
    end else if (uart_rx_done) begin
      rx_byte  <= uart_rx_data;
      rx_ready <= 1'b1;
    end else if (Clean_rx_Memwrite) begin
      rx_ready <= 1'b0;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  // Sticky flag: a new byte arrived before the previous one was cleared.
  logic overrun;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       overrun <= 1'b0;
    else if (uart_rx_done && rx_ready) overrun <= 1'b1;
    else if (Clean_rx_Memwrite)        overrun <= 1'b0;
  end
  assign overrun_bit = overrun;
`else
  assign overrun_bit = 1'b0;
`endif

  // ---------------- Read words ----------------
  assign Rx_ReadData       = {{(DATA_WIDTH-8){1'b0}}, rx_byte};
  assign Rx_ready_ReadData = {{(DATA_WIDTH-3){1'b0}}, (state != TX_IDLE),
                              overrun_bit, rx_ready};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_ctrl
//   Directed bench for uart_mmio_ctrl. Inputs change on the falling clock
//   edge and outputs are sampled on the falling edge, half a cycle after the
//   rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_uart_mmio_ctrl;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [DW-1:0] WriteData;
  logic          Tx_MemWrite;
  logic          Tx_data_Memwrite;
  logic          Clean_rx_Memwrite;
  logic [DW-1:0] Rx_ReadData;
  logic [DW-1:0] Rx_ready_ReadData;
  logic          uart_tx_start;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_busy;
  logic          uart_rx_done;
  logic [7:0]    uart_rx_data;
  logic [1:0]    dbg_tx_state;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulse;

`ifdef UART_RX_OVERRUN_EN
  localparam logic [DW-1:0] EXP_OVR_STATUS = 32'h3;
`else
  localparam logic [DW-1:0] EXP_OVR_STATUS = 32'h1;
`endif

  uart_mmio_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .WriteData         (WriteData),
    .Tx_MemWrite       (Tx_MemWrite),
    .Tx_data_Memwrite  (Tx_data_Memwrite),
    .Clean_rx_Memwrite (Clean_rx_Memwrite),
    .Rx_ReadData       (Rx_ReadData),
    .Rx_ready_ReadData (Rx_ready_ReadData),
    .uart_tx_start     (uart_tx_start),
    .uart_tx_data      (uart_tx_data),
    .uart_tx_busy      (uart_tx_busy),
    .uart_rx_done      (uart_rx_done),
    .uart_rx_data      (uart_rx_data),
    .dbg_tx_state      (dbg_tx_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge to the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    WriteData         = '0;
    Tx_MemWrite       = 1'b0;
    Tx_data_Memwrite  = 1'b0;
    Clean_rx_Memwrite = 1'b0;
    uart_rx_done      = 1'b0;
    uart_rx_data      = 8'h00;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    uart_tx_busy = 1'b0;
    reset        = 1'b0;
    #1;
    chk("reset_status", Rx_ready_ReadData, 32'h0);
    chk("reset_rxdata", Rx_ReadData, 32'h0);
    chk("reset_txdata", {24'h0, uart_tx_data}, 32'h0);
    chk("reset_start",  {31'h0, uart_tx_start}, 32'h0);
    step(); step();
    reset = 1'b1;
    step();

    // Load 0x41, then issue the start store.
    Tx_data_Memwrite = 1'b1; WriteData = 32'h41;
    step();
    idle_inputs();
    chk("txdata_loaded", {24'h0, uart_tx_data}, 32'h41);
    chk("no_start_yet",  {31'h0, uart_tx_start}, 32'h0);
    Tx_MemWrite = 1'b1; WriteData = 32'h1;
    step();
    idle_inputs();
    chk("start_pulse",    {31'h0, uart_tx_start}, 32'h1);
    chk("start_data",     {24'h0, uart_tx_data}, 32'h41);
    chk("busy_in_start",  Rx_ready_ReadData, 32'h4);
    step();
    chk("start_one_cycle", {31'h0, uart_tx_start}, 32'h0);
    chk("status_wait_busy", Rx_ready_ReadData, 32'h4);

    // Serializer busy for 100 cycles, with a second start and a 0x55 data
    // store in the middle of the frame.
    uart_tx_busy = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 40) begin Tx_MemWrite = 1'b1; WriteData = 32'h1; end
      if (i == 50) begin Tx_data_Memwrite = 1'b1; WriteData = 32'h55; end
      step();
      idle_inputs();
      if (uart_tx_start) n_pulse++;
      if (Rx_ready_ReadData !== 32'h4) n_pulse += 1000;
    end
    chk("midframe_no_pulse_busyflag", n_pulse, 0);
    chk("midframe_byte_kept", {24'h0, uart_tx_data}, 32'h41);
    uart_tx_busy = 1'b0;
    step();
    chk("frame_done_status", Rx_ready_ReadData, 32'h0);
    chk("frame_done_start",  {31'h0, uart_tx_start}, 32'h0);

    // A start store with WriteData[0]=0 must not start.
    Tx_MemWrite = 1'b1; WriteData = 32'hFE;
    step();
    idle_inputs();
    step();
    chk("bit0_zero_no_start", {31'h0, uart_tx_start}, 32'h0);
    chk("bit0_zero_idle",     Rx_ready_ReadData, 32'h0);

    // Data store and start store in the same idle cycle.
    Tx_data_Memwrite = 1'b1; Tx_MemWrite = 1'b1; WriteData = 32'h99;
    step();
    idle_inputs();
    chk("same_cycle_pulse", {31'h0, uart_tx_start}, 32'h1);
    chk("same_cycle_data",  {24'h0, uart_tx_data}, 32'h99);
    uart_tx_busy = 1'b1;
    step(); step(); step();
    uart_tx_busy = 1'b0;
    step();
    chk("same_cycle_done", Rx_ready_ReadData, 32'h0);

    // RX capture, then clean.
    uart_rx_done = 1'b1; uart_rx_data = 8'h7E;
    step();
    idle_inputs();
    chk("rx_data_7e",   Rx_ReadData, 32'h7E);
    chk("rx_status_7e", Rx_ready_ReadData, 32'h1);
    Clean_rx_Memwrite = 1'b1; WriteData = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    chk("clean_status", Rx_ready_ReadData, 32'h0);
    chk("clean_kept",   Rx_ReadData, 32'h7E);

    // rx_done and clean together: rx_done wins.
    uart_rx_done = 1'b1; uart_rx_data = 8'h33; Clean_rx_Memwrite = 1'b1;
    step();
    idle_inputs();
    chk("race_status", Rx_ready_ReadData, 32'h1);
    chk("race_data",   Rx_ReadData, 32'h33);
    Clean_rx_Memwrite = 1'b1;
    step();
    idle_inputs();
    chk("race_cleaned", Rx_ready_ReadData, 32'h0);

    // Two bytes with no clean in between.
    uart_rx_done = 1'b1; uart_rx_data = 8'h10;
    step();
    uart_rx_data = 8'h20;
    step();
    idle_inputs();
    chk("overwrite_data",   Rx_ReadData, 32'h20);
    chk("overwrite_status", Rx_ready_ReadData, EXP_OVR_STATUS);
    Clean_rx_Memwrite = 1'b1;
    step();
    idle_inputs();
    chk("overwrite_clean", Rx_ready_ReadData, 32'h0);

    // Reset in TX_WAIT_DONE with an RX byte pending.
    uart_rx_done = 1'b1; uart_rx_data = 8'hA5;
    Tx_data_Memwrite = 1'b1; Tx_MemWrite = 1'b1; WriteData = 32'h0000_00C3;
    step();
    idle_inputs();
    step();
    uart_tx_busy = 1'b1;
    step(); step();
    chk("pre_reset_status", Rx_ready_ReadData, 32'h5);
    reset = 1'b0;
    #1;
    chk("async_status", Rx_ready_ReadData, 32'h0);
    chk("async_start",  {31'h0, uart_tx_start}, 32'h0);
    chk("async_txdata", {24'h0, uart_tx_data}, 32'h0);
    chk("async_rxdata", Rx_ReadData, 32'h0);
    step();
    uart_tx_busy = 1'b0;
    reset = 1'b1;
    step();
    Tx_MemWrite = 1'b1; WriteData = 32'h1;
    step();
    idle_inputs();
    chk("post_reset_pulse", {31'h0, uart_tx_start}, 32'h1);
    step();
    chk("post_reset_single", {31'h0, uart_tx_start}, 32'h0);
    uart_tx_busy = 1'b1;
    step();
    uart_tx_busy = 1'b0;
    step();
    chk("post_reset_idle", Rx_ready_ReadData, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
